conveyor_alarm_encoder: RTL
===========================

# conveyor_alarm_encoder

Producer side of the conveyor alarm interface: turns a raw sensor sample stream (load/temperature) into the debounced, hysteretic `A` (warning) and `C` (critical) levels consumed by `SmartConveyor_Control`. It sits between the sensor front-end and the conveyor control FSM. It guarantees `A` and `C` are never asserted together and never chatter. Critical can be latched until an operator clear.

## Interface

**Parameters**
- `DATA_W`, 8: sample width.
- `WARN_TH`, 100: warning threshold, unsigned.
- `CRIT_TH`, 180: critical threshold. Must satisfy `WARN_TH < CRIT_TH < 2**DATA_W`.
- `HYST`, 10: de-escalation hysteresis. Must satisfy `HYST <= WARN_TH`.
- `DEB_N`, 3: consecutive valid samples required for any state change. Must be ≥ 1.
- `LATCH_CRIT`, 1: 1 means critical holds until `crit_clr`; 0 means it auto-releases.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sample_valid`, in, 1: qualifies `sample` for this cycle.
- `sample`, in, `DATA_W`: raw sensor value.
- `crit_clr`, in, 1: operator clear, single-cycle pulse.
- `A`, out, 1: warning level to the controller.
- `C`, out, 1: critical level to the controller.
- `state`, out, 2: encoded state, for debug.

## Operation

- **States** (`state` encoding): NORMAL=0, WARN=1, CRIT=2, CRIT_HOLD=3.
- **Outputs** (registered, decoded from state):
  - `A` = 1 only in WARN.
  - `C` = 1 in CRIT and CRIT_HOLD.
  - `A` and `C` are mutually exclusive.
- **Per-valid-sample classification** (unsigned compares):
  - `hi_crit` = `sample >= CRIT_TH`.
  - `hi_warn` = `sample >= WARN_TH`.
  - `lo_warn` = `sample < WARN_TH-HYST`.
  - `lo_crit` = `sample < CRIT_TH-HYST`.
- **Counters:** three saturating counters, each `$clog2(DEB_N+1)` bits.
  - `crit_cnt` counts consecutive `hi_crit`.
  - `warn_cnt` counts consecutive `hi_warn`.
  - `clr_cnt` counts consecutive de-escalation samples for the current state.
  - A valid sample failing a counter's condition zeroes that counter.
  - Cycles with `sample_valid=0` leave all counters unchanged.
  - All counters zero on every state transition.
- **Transitions** (evaluated on a valid sample; "reaches" means the counter hits `DEB_N` including the current sample):
  - NORMAL:
    - `crit_cnt` reaches `DEB_N` → CRIT.
    - Otherwise, `warn_cnt` reaches `DEB_N` → WARN.
    - Critical has priority over warning.
  - WARN:
    - `crit_cnt` reaches `DEB_N` → CRIT.
    - Otherwise, `clr_cnt` (counting `lo_warn`) reaches `DEB_N` → NORMAL.
    - Samples in `[WARN_TH-HYST, CRIT_TH)` hold WARN.
  - CRIT:
    - `clr_cnt` (counting `lo_crit`) reaches `DEB_N` → CRIT_HOLD if `LATCH_CRIT=1`, else WARN.
  - CRIT_HOLD:
    - `crit_clr=1` → WARN.
    - Otherwise, `crit_cnt` reaches `DEB_N` → CRIT.
    - `crit_clr` is evaluated every cycle, independent of `sample_valid`.
- **`crit_clr` outside CRIT_HOLD:** ignored. It is not remembered.
- **Simultaneous events in CRIT_HOLD:** `crit_clr` and a completing `crit_cnt` in the same cycle → CRIT. Critical wins.
- **Edge value with `HYST=WARN_TH`:** `lo_warn` can never be true, so WARN is left only upward. This is legal.

## Timing

- Reset (asynchronous assert): state=NORMAL, `A=0`, `C=0`, `state=0`, all counters 0, effective immediately without waiting for a clock.
- Reset release: the first valid sample is accepted on the first rising edge with `rst_n=1`.
- **Latency:** the state changes on the rising edge that samples the `DEB_N`-th qualifying valid sample. `A`/`C` are valid directly after that edge. There is no extra pipeline stage.
- **Minimum time to an output change:** `DEB_N` valid cycles.
- **`crit_clr` latency:** WARN (`A=1`, `C=0`) is visible after the edge that samples `crit_clr`.
- **Reset mid-operation:** any in-flight debounce count is discarded and `C` drops immediately.

## Test plan

All scenarios use defaults (`DEB_N=3`, `WARN_TH=100`, `CRIT_TH=180`, `HYST=10`, `LATCH_CRIT=1`).

- **Reset and debounce break:**
  - Reset → `A=0`, `C=0`, `state=0`.
  - Valid samples 120, 50, 120, 120 → `A` stays 0.
  - A further 120 → `A=1` after that edge.
- **Gaps and direct escalation:**
  - From NORMAL: valid 200, then `sample_valid=0` with `sample=250` for 2 cycles, then valid 200, 200 → `C=1`, `A=0` after the third valid sample, with no intermediate `A` pulse.
- **Latch and clear path:**
  - In CRIT: valid 175 ×3 (still at or above 170) → stays CRIT.
  - Valid 165 ×3 → CRIT_HOLD, `C=1`.
  - `crit_clr` pulse → `A=1`, `C=0`, `state=1`.
- **Hysteresis in WARN:**
  - Valid 95 ×5 → stays WARN.
  - Valid 85 ×3 → NORMAL, `A=0`.
- **Simultaneous clear and re-escalation:**
  - In CRIT_HOLD: valid 190, 190, then 190 in the same cycle as `crit_clr=1` → CRIT, `C=1`.
  - `crit_clr` pulse while in CRIT → no effect.
- **Asynchronous reset mid-CRIT:**
  - Assert `rst_n=0` between clock edges → `C=0`, `state=0` before the next edge.
  - Counters restart from zero after release.

Source files
------------

// File: rtl/conveyor_alarm_encoder.sv
// Debounced, hysteretic alarm encoder: turns a raw load/temperature sample stream
// into mutually exclusive warning (A) and critical (C) levels for the conveyor controller.
module conveyor_alarm_encoder #(
  parameter int DATA_W     = 8,
  parameter int WARN_TH    = 100,
  parameter int CRIT_TH    = 180,
  parameter int HYST       = 10,
  parameter int DEB_N      = 3,
  parameter int LATCH_CRIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              crit_clr,
  output logic              A,
  output logic              C,
  output logic [1:0]        state
);

  localparam int CW = $clog2(DEB_N + 1);

  localparam logic [CW-1:0]     DEB_V   = CW'(DEB_N);
  localparam logic [DATA_W-1:0] WARN_V  = DATA_W'(WARN_TH);
  localparam logic [DATA_W-1:0] CRIT_V  = DATA_W'(CRIT_TH);
  localparam logic [DATA_W-1:0] LO_W_V  = DATA_W'(WARN_TH - HYST);
  localparam logic [DATA_W-1:0] LO_C_V  = DATA_W'(CRIT_TH - HYST);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_WARN   = 2'd1,
    ST_CRIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] crit_cnt_q, crit_cnt_d;
  logic [CW-1:0] warn_cnt_q, warn_cnt_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          a_q, c_q;

  logic          hi_crit_s, hi_warn_s, lo_warn_s, lo_crit_s, clr_cond_s;
  logic [CW-1:0] crit_inc_s, warn_inc_s, clr_inc_s;
  logic          crit_done_s, warn_done_s, clr_done_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    if (cnt >= DEB_V) begin
      return DEB_V;
    end else begin
      return cnt + CW'(1);
    end
  endfunction

  // Classify the sample, advance debounce counters and pick the next state.
  always_comb begin
    hi_crit_s = (sample >= CRIT_V);
    hi_warn_s = (sample >= WARN_V);
    lo_warn_s = (sample < LO_W_V);
    lo_crit_s = (sample < LO_C_V);

    // De-escalation condition depends on where we currently are.
    case (state_q)
      ST_WARN: clr_cond_s = lo_warn_s;
      ST_CRIT: clr_cond_s = lo_crit_s;
      default: clr_cond_s = 1'b0;
    endcase

    crit_inc_s = hi_crit_s  ? sat_inc(crit_cnt_q) : {CW{1'b0}};
    warn_inc_s = hi_warn_s  ? sat_inc(warn_cnt_q) : {CW{1'b0}};
    clr_inc_s  = clr_cond_s ? sat_inc(clr_cnt_q)  : {CW{1'b0}};

    crit_done_s = sample_valid && (crit_inc_s == DEB_V);
    warn_done_s = sample_valid && (warn_inc_s == DEB_V);
    clr_done_s  = sample_valid && (clr_inc_s  == DEB_V);

    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (crit_done_s) begin
          state_d = ST_CRIT;
        end else if (warn_done_s) begin
          state_d = ST_WARN;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_WARN: begin
        if (crit_done_s) begin
          state_d = ST_CRIT;
        end else if (clr_done_s) begin
          state_d = ST_NORMAL;
        end else begin
          state_d = ST_WARN;
        end
      end
      ST_CRIT: begin
        if (clr_done_s) begin
          state_d = (LATCH_CRIT != 0) ? ST_HOLD : ST_WARN;
        end else begin
          state_d = ST_CRIT;
        end
      end
      ST_HOLD: begin
        // A completing re-escalation beats a simultaneous operator clear.
        if (crit_done_s) begin
          state_d = ST_CRIT;
        end else if (crit_clr) begin
          state_d = ST_WARN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    if (state_d != state_q) begin
      crit_cnt_d = {CW{1'b0}};
      warn_cnt_d = {CW{1'b0}};
      clr_cnt_d  = {CW{1'b0}};
    end else if (sample_valid) begin
      crit_cnt_d = crit_inc_s;
      warn_cnt_d = warn_inc_s;
      clr_cnt_d  = clr_inc_s;
    end else begin
      crit_cnt_d = crit_cnt_q;
      warn_cnt_d = warn_cnt_q;
      clr_cnt_d  = clr_cnt_q;
    end
  end

  // State, counters and outputs decoded from the next state so A/C track state with no lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_NORMAL;
      crit_cnt_q <= {CW{1'b0}};
      warn_cnt_q <= {CW{1'b0}};
      clr_cnt_q  <= {CW{1'b0}};
      a_q        <= 1'b0;
      c_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      crit_cnt_q <= crit_cnt_d;
      warn_cnt_q <= warn_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      a_q        <= (state_d == ST_WARN);
      c_q        <= (state_d == ST_CRIT) || (state_d == ST_HOLD);
    end
  end

  assign A     = a_q;
  assign C     = c_q;
  assign state = state_q;

endmodule
